mmv_ram_slave: RTL

//   MemoryMapped slave built on a word-addressed RAM, with a fixed read latency.

---
 rtl/mmv_ram_slave.sv | 114 +++++++++++
 1 files changed

// File: rtl/mmv_ram_slave.sv
// mmv_ram_slave: memory-mapped slave on a word-addressed RAM.
// After every reset the RAM is cleared one word per clock (INIT). Then
// requests are accepted whenever stall is low. Reads return in order after a
// fixed RDLAT-clock latency, and one read can be accepted per clock.
module mmv_ram_slave #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 32,
  parameter int RAWIDTH = 8,
  parameter int RDLAT   = 2,
  // Raise a simulation $error when a write and a read are requested together
  parameter bit REPORT_CONFLICT = 1'b1
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_rval,
  output logic              s_busy,
  input  logic              stall
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t             state_reg;
  logic [RAWIDTH-1:0] cnt_reg;
  logic [DWIDTH-1:0]  mem [2**RAWIDTH];

  logic [RAWIDTH-1:0] idx;
  logic               accept;
  logic               wr_en;
  logic               rd_en;
  logic               unused_addr;

  // The RAM index is taken from the low address bits, so addresses alias
  // modulo the RAM depth.
  assign idx         = s_addr[RAWIDTH-1:0];
  assign unused_addr = ^s_addr;

  // The slave is busy for the whole clear sweep. After that, only stall
  // holds off requests.
  assign s_busy = (state_reg == ST_INIT) | stall;
  assign accept = (s_wreq | s_rreq) & ~s_busy;
  // If both requests are present, the write wins and the read is dropped.
  assign wr_en  = accept & s_wreq;
  assign rd_en  = accept & s_rreq & ~s_wreq;

  // Clear-sweep sequencer: walk every RAM index once, then stay READY until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (&cnt_reg) state_reg <= ST_READY;
        end
        default: state_reg <= ST_READY;
      endcase
    end
  end

  // RAM write port: zero fill during the sweep, master writes afterwards
  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) mem[cnt_reg] <= '0;
    else if (wr_en)           mem[idx]     <= s_wdat;
  end

  // Read pipeline. Stage 0 is the registered RAM read. Each stage's data
  // register loads only on a valid transfer, so the last stage holds the
  // most recent response while s_rval is low.
  logic [RDLAT-1:0]  val_reg;
  logic [DWIDTH-1:0] dat_reg [RDLAT];

  // Stage 0: capture the RAM word on the edge where a read is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_reg[0] <= 1'b0;
      dat_reg[0] <= '0;
    end else begin
      val_reg[0] <= rd_en;
      if (rd_en) dat_reg[0] <= mem[idx];
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < RDLAT; gi++) begin : g_stage
      // Later stages: shift the response one stage per clock, ignoring stall
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          val_reg[gi] <= 1'b0;
          dat_reg[gi] <= '0;
        end else begin
          val_reg[gi] <= val_reg[gi-1];
          if (val_reg[gi-1]) dat_reg[gi] <= dat_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s_rval = val_reg[RDLAT-1];
  assign s_rdat = dat_reg[RDLAT-1];

  // Flag a simultaneous write and read request that gets accepted
  always @(posedge clk) begin
    if (REPORT_CONFLICT && !reset && accept && s_wreq && s_rreq)
      $error("mmv_ram_slave: s_wreq and s_rreq both high, read discarded");
  end

endmodule
